// File: rtl/eth_tx_arbiter.sv
// Two-source round-robin frame arbiter feeding an EMAC client TX port.
// One frame at a time, first byte held until EMAC ack, then an inter-frame gap.

module eth_tx_frame_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             eth_tx_clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge eth_tx_clk) begin
    if (rst)      count <= '0;
    else if (inc) count <= count + 1'b1;
  end
endmodule

module eth_tx_arbiter #(
  parameter int IFG_CYCLES = 8,
  parameter int CNT_W      = 16
) (
  input  logic             eth_tx_clk,
  input  logic             rst,
  input  logic             src0_req,
  input  logic [7:0]       src0_data,
  input  logic             src0_last,
  output logic             src0_rden,
  input  logic             src1_req,
  input  logic [7:0]       src1_data,
  input  logic             src1_last,
  output logic             src1_rden,
  output logic [7:0]       eth_tx_data,
  output logic             eth_tx_data_en,
  input  logic             eth_tx_ack,
  output logic             busy,
  output logic             grant,
  output logic [CNT_W-1:0] frames0,
  output logic [CNT_W-1:0] frames1
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] STREAM   = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;
  localparam logic [7:0] IFG8     = IFG_CYCLES[7:0];

  logic [1:0]            state;
  logic                  prio;
  logic [7:0]            gap_cnt;
  logic [1:0]            req, last, inc;
  logic [1:0][7:0]       data;
  logic [1:0][CNT_W-1:0] cnt;
  logic                  win, en, xfer, done;

  assign req  = {src1_req, src0_req};
  assign last = {src1_last, src0_last};
  assign data = {src1_data, src0_data};

  // On contention prio decides; otherwise the lone requester wins.
  assign win  = (req == 2'b11) ? prio : req[1];
  assign en   = (state == WAIT_ACK) || (state == STREAM);
  assign xfer = ((state == WAIT_ACK) && eth_tx_ack) || (state == STREAM);
  assign done = xfer && last[grant];

  assign eth_tx_data_en = en;
  assign eth_tx_data    = en ? data[grant] : 8'h00;
  assign src0_rden      = xfer && !grant;
  assign src1_rden      = xfer && grant;
  assign busy           = (state != IDLE);
  assign inc            = {done && grant, done && !grant};

  always_ff @(posedge eth_tx_clk) begin
    if (rst) begin
      state   <= IDLE;
      prio    <= 1'b0;
      grant   <= 1'b0;
      gap_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant <= win;
          state <= WAIT_ACK;
        end
        WAIT_ACK, STREAM: if (done) begin
          state   <= GAP;
          prio    <= ~grant;
          gap_cnt <= IFG8;
        end else if (xfer) begin
          state <= STREAM;
        end
        GAP: begin
          // Loaded with IFG on entry, so GAP spans IFG_CYCLES+1 cycles.
          if (gap_cnt == 8'd0) state   <= IDLE;
          else                 gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    eth_tx_frame_cnt #(.CNT_W(CNT_W)) u_cnt (
      .eth_tx_clk (eth_tx_clk),
      .rst        (rst),
      .inc        (inc[i]),
      .count      (cnt[i])
    );
  end

  assign frames0 = cnt[0];
  assign frames1 = cnt[1];
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized bench: two arbiters (IFG 8/CNT 16 and IFG 0/CNT 4) fed by frame
// queues, compared every cycle against a frame-level reference model.

module tb_eth_tx_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req_v, last_v;
  logic [7:0] data_v [4];
  logic [1:0] ack;
  wire  [3:0] rden;
  wire  [1:0] en, busy, grant;
  wire  [7:0] txd0, txd1;
  wire [15:0] fa0, fa1;
  wire  [3:0] fb0, fb1;

  eth_tx_arbiter #(.IFG_CYCLES(8), .CNT_W(16)) u_dut0 (
    .eth_tx_clk(clk), .rst(rst),
    .src0_req(req_v[0]), .src0_data(data_v[0]), .src0_last(last_v[0]), .src0_rden(rden[0]),
    .src1_req(req_v[1]), .src1_data(data_v[1]), .src1_last(last_v[1]), .src1_rden(rden[1]),
    .eth_tx_data(txd0), .eth_tx_data_en(en[0]), .eth_tx_ack(ack[0]),
    .busy(busy[0]), .grant(grant[0]), .frames0(fa0), .frames1(fa1));

  eth_tx_arbiter #(.IFG_CYCLES(0), .CNT_W(4)) u_dut1 (
    .eth_tx_clk(clk), .rst(rst),
    .src0_req(req_v[2]), .src0_data(data_v[2]), .src0_last(last_v[2]), .src0_rden(rden[2]),
    .src1_req(req_v[3]), .src1_data(data_v[3]), .src1_last(last_v[3]), .src1_rden(rden[3]),
    .eth_tx_data(txd1), .eth_tx_data_en(en[1]), .eth_tx_ack(ack[1]),
    .busy(busy[1]), .grant(grant[1]), .frames0(fb0), .frames1(fb1));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Source byte queues, index inst*2+src; bit 8 marks the last byte of a frame.
  logic [8:0] sq [4][$];

  // Reference model: who owns the link, whether its first byte was taken,
  // idle cycles still owed, preferred source, completed frame totals.
  bit [1:0] m_on, m_acked, m_pref, m_src;
  int       m_gap [2];
  int       m_fr  [4];
  bit       armed = 0;

  function automatic int ifg(input int k);  return (k == 0) ? 8 : 0;         endfunction
  function automatic int cmask(input int k); return (k == 0) ? 65535 : 15;   endfunction

  task automatic cycle(input int fill, input int reqp, input int ackp, input int rstp, input int maxlen);
    logic [8:0]  e;
    logic [12:0] got, exp;
    logic [1:0]  e_rden;
    logic [7:0]  e_data;
    bit          e_rd;
    int          idx, pick;
    @(negedge clk);
    rst = ($urandom_range(99) < rstp);
    for (int i = 0; i < 4; i++) begin
      if (sq[i].size() == 0 && $urandom_range(99) < fill) begin
        int len = $urandom_range(maxlen, 1);
        for (int j = 0; j < len; j++) begin
          e = {1'b0, 8'($urandom)};
          e[8] = (j == len - 1);
          sq[i].push_back(e);
        end
      end
      req_v[i]  = (sq[i].size() > 0) && ($urandom_range(99) < reqp);
      if (sq[i].size() > 0) begin
        data_v[i] = sq[i][0][7:0];
        last_v[i] = sq[i][0][8];
      end else begin
        data_v[i] = 8'($urandom);
        last_v[i] = 1'($urandom);
      end
    end
    for (int k = 0; k < 2; k++) ack[k] = ($urandom_range(99) < ackp);
    #1;
    for (int k = 0; k < 2; k++) begin
      idx    = k * 2 + int'(m_src[k]);
      e_rd   = m_on[k] && (m_acked[k] || ack[k]);
      e_rden = e_rd ? (m_src[k] ? 2'b10 : 2'b01) : 2'b00;
      e_data = m_on[k] ? data_v[idx] : 8'h00;
      if (armed) begin
        exp = {(m_on[k] || m_gap[k] > 0), m_src[k], m_on[k], e_rden, e_data};
        if (k == 0) got = {busy[0], grant[0], en[0], rden[1], rden[0], txd0};
        else        got = {busy[1], grant[1], en[1], rden[3], rden[2], txd1};
        chk($sformatf("out%0d", k), 32'(got), 32'(exp));
        if (k == 0) chk("frames0", {fa1, fa0}, {m_fr[1][15:0], m_fr[0][15:0]});
        else        chk("frames1", {24'd0, fb1, fb0}, {24'd0, m_fr[3][3:0], m_fr[2][3:0]});
      end
      // Advance model across the coming clock edge.
      if (e_rd) void'(sq[idx].pop_front());
      if (rst) begin
        m_on[k] = 0; m_acked[k] = 0; m_pref[k] = 0; m_src[k] = 0; m_gap[k] = 0;
        m_fr[k*2] = 0; m_fr[k*2+1] = 0;
      end else if (m_on[k]) begin
        if (e_rd && last_v[idx]) begin
          m_on[k]   = 0;
          m_fr[idx] = (m_fr[idx] + 1) & cmask(k);
          m_pref[k] = !m_src[k];
          m_gap[k]  = ifg(k) + 1;
        end else if (e_rd) m_acked[k] = 1;
      end else if (m_gap[k] > 0) begin
        m_gap[k]--;
      end else if (req_v[k*2] || req_v[k*2+1]) begin
        pick = (req_v[k*2] && req_v[k*2+1]) ? int'(m_pref[k]) : int'(req_v[k*2+1]);
        m_on[k] = 1; m_acked[k] = 0; m_src[k] = 1'(pick);
      end
    end
    if (rst) armed = 1;
  endtask

  task automatic run(input int n, input int fill, input int reqp, input int ackp, input int rstp, input int maxlen);
    for (int c = 0; c < n; c++) cycle(fill, reqp, ackp, rstp, maxlen);
  endtask

  initial begin
    rst = 1'b1; req_v = '0; last_v = '0; ack = '0;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
    run(3, 0, 0, 0, 100, 1);          // reset, then reset-state checks
    run(800, 30, 80, 50, 0, 6);       // sparse traffic, withdrawn requests
    run(800, 100, 100, 100, 0, 1);    // contention, single-byte frames
    run(800, 100, 100, 30, 0, 8);     // contention, slow ack
    run(1500, 60, 70, 60, 1, 10);     // occasional mid-frame resets
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 8, number of idle cycles inserted after each frame before the next grant; legal range 0..255.
REQ-002 Parameter CNT_W, default 16, width of the per-source frame counters.
REQ-003 eth_tx_clk  input  1  sole clock; every register samples on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 src0_req  input  1  source 0 (ARP/control) has a frame ready; its first byte is on src0_data.
REQ-006 src0_data  input  8  source 0 current byte, first-word-fall-through.
REQ-007 src0_last  input  1  src0_data is the final byte of the frame.
REQ-008 src0_rden  output  1  source 0 current byte consumed; source presents next byte on the following cycle.
REQ-009 src1_req, src1_data[7:0], src1_last, src1_rden: source 1 (UDP), same directions, widths and meaning as source 0.
REQ-010 eth_tx_data  output  8  byte to EMAC client TX interface.
REQ-011 eth_tx_data_en  output  1  frame valid to EMAC; held high from first byte through last byte.
REQ-012 eth_tx_ack  input  1  EMAC accepted the first byte; EMAC takes one byte per cycle from the following cycle on.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant  output  1  index of the source currently granted; held from grant until the next grant.
REQ-015 frames0, frames1  output  CNT_W  completed frames per source, wrapping modulo 2^CNT_W.

Function
REQ-016 States IDLE, WAIT_ACK, STREAM, GAP; eth_tx_data_en = 1 exactly in WAIT_ACK and STREAM, decoded from the state register.
REQ-017 IDLE: requests sampled only here; if any srcN_req = 1, the arbiter registers the winner in grant and enters WAIT_ACK on the next edge, giving a one-cycle req-to-eth_tx_data_en latency.
REQ-018 Round-robin: priority register prio (reset 0) names the preferred source; on a simultaneous request the source named by prio wins; with a single request, that source wins regardless of prio.
REQ-019 prio becomes the non-granted source index when the arbiter enters GAP.
REQ-020 eth_tx_data = data of the granted source in WAIT_ACK and STREAM, 8'h00 otherwise; combinational mux, no added latency.
REQ-021 WAIT_ACK: the first byte is held and srcN_rden stays 0 until eth_tx_ack = 1; there is no timeout.
REQ-022 srcN_rden = 1 for the granted source in a WAIT_ACK cycle with eth_tx_ack = 1 and in every STREAM cycle; it is 0 for the other source in all states.
REQ-023 Leaving WAIT_ACK on eth_tx_ack: go to GAP if the granted srcN_last = 1 (single-byte frame), else go to STREAM.
REQ-024 STREAM: one byte is consumed per cycle; in the cycle where the granted srcN_last = 1, go to GAP, so eth_tx_data_en falls on the cycle after the last byte.
REQ-025 srcN_req is ignored outside IDLE; deasserting req mid-frame does not end the frame; only srcN_last ends it.
REQ-026 Each transition into GAP increments the frame counter of the granted source by 1, with wrap from 2^CNT_W-1 to 0.
REQ-027 GAP lasts IFG_CYCLES+1 cycles using an 8-bit down-counter loaded on entry, then the arbiter returns to IDLE; with IFG_CYCLES = 0, GAP lasts 1 cycle.
REQ-028 Back-to-back requests from the same source are served only after GAP; a pending other source always wins the next IDLE cycle after a frame.

Reset
REQ-029 On rst = 1 at a clock edge: state = IDLE, prio = 0, grant = 0, gap counter = 0, frames0 = frames1 = 0.
REQ-030 Outputs after that edge: eth_tx_data_en = 0, eth_tx_data = 8'h00, src0_rden = src1_rden = 0, busy = 0.
REQ-031 Reset mid-frame aborts the frame immediately with no counter increment; sources are responsible for flushing; rst has priority over every transition.

Verification
REQ-032 Single frame: src1 sends 4 bytes A1..A4, ack 3 cycles after en rises -> en high 3+4 cycles, bytes A1,A2,A3,A4 in order, src1_rden high 4 cycles, frames1 = 1, busy low 10 cycles after last byte (IFG_CYCLES = 8).
REQ-033 Contention: src0_req and src1_req asserted in the same IDLE cycle after reset -> src0 served first, then src1 after the GAP; with both held, the grants alternate 0,1,0,1.
REQ-034 Single-byte frame: src0_last = 1 on the first byte -> en high through the ack cycle only, one src0_rden pulse, frames0 = 1.
REQ-035 Reset in STREAM after 2 of 6 bytes -> en = 0 and rden = 0 on the next cycle, frames unchanged, state IDLE, a new request is granted normally.
REQ-036 Counter wrap: CNT_W = 4 and 17 frames from src1 -> frames1 = 1; IFG_CYCLES = 0 -> exactly 1 idle cycle between frames.
REQ-037 Request withdrawn: src1_req dropped during WAIT_ACK -> frame still completes on src1_last, frames1 = 1.
